// File: rtl/codeword_packer_pkg.sv
// Shared types and helpers for the codeword packer: FSM states, accumulator
// sizing and the codeword length legality check used by the codebook stage.
package codeword_packer_pkg;

    localparam int LEN_W = 6;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // Headroom of one maximal codeword above a full output word.
    function automatic int acc_width(input int out_width, input int data_length);
        return out_width + data_length;
    endfunction

    function automatic logic len_is_legal(input logic [LEN_W-1:0] len, input int max_len);
        return (32'(len) <= 32'(max_len));
    endfunction

endpackage

// File: rtl/codeword_packer_if.sv
// Codeword input and packed-word output handshakes of the codeword packer.
// The packer uses the slave modport; the feeding/consuming side uses master.
interface codeword_packer_if #(
    parameter int ENCODE_DATALENGTH = 21,
    parameter int OUT_WIDTH         = 32
);
    import codeword_packer_pkg::*;

    logic                         encode_valid_i;
    logic                         encode_ready_o;
    logic                         encode_match_i;
    logic [LEN_W-1:0]             encode_match_length_i;
    logic [ENCODE_DATALENGTH-1:0] encode_match_data_i;
    logic [OUT_WIDTH-1:0]         out_data_o;
    logic                         out_valid_o;
    logic                         out_ready_i;

    modport slave (
        input  encode_valid_i, encode_match_i, encode_match_length_i,
               encode_match_data_i, out_ready_i,
        output encode_ready_o, out_data_o, out_valid_o
    );

    modport master (
        output encode_valid_i, encode_match_i, encode_match_length_i,
               encode_match_data_i, out_ready_i,
        input  encode_ready_o, out_data_o, out_valid_o
    );

endinterface

// File: rtl/codeword_packer.sv
// Packs variable-length codewords MSB-first into OUT_WIDTH-bit words, with flush.
// Define CODEWORD_PACKER_BITCNT_EN to add the bit_count_o accepted-bit counter.
module codeword_packer
    import codeword_packer_pkg::*;
#(
    parameter int ENCODE_DATALENGTH = 21,
    parameter int OUT_WIDTH         = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    codeword_packer_if.slave        bus,
    input  logic                    flush_i,
    output logic                    flush_done_o,
    output logic                    len_err_o
`ifdef CODEWORD_PACKER_BITCNT_EN
    ,
    output logic [31:0]             bit_count_o
`endif
);

    localparam int ACC_W = acc_width(OUT_WIDTH, ENCODE_DATALENGTH);
    localparam int CNT_W = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] OW_CNT = CNT_W'(OUT_WIDTH);

    state_e               state_q;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 ready_q;
    logic                 flush_done_q;
    logic                 len_err_q;

    logic accept, beat_legal, append, out_free, drain, pad;

    // Places data[len-1:0] directly below the cnt bits already held.
    function automatic logic [ACC_W-1:0] insert_bits(
        input logic [ACC_W-1:0]             acc,
        input logic [ENCODE_DATALENGTH-1:0] data,
        input logic [LEN_W-1:0]             len,
        input logic [CNT_W-1:0]             cnt
    );
        logic [ENCODE_DATALENGTH-1:0] ones;
        logic [ACC_W-1:0]             field;
        ones  = '1;
        field = ACC_W'(data & (ones >> (ENCODE_DATALENGTH - int'(len))));
        return acc | (field << (ACC_W - int'(cnt) - int'(len)));
    endfunction

    always_comb begin
        accept     = bus.encode_valid_i && ready_q;
        beat_legal = len_is_legal(bus.encode_match_length_i, ENCODE_DATALENGTH);
        append     = accept && bus.encode_match_i && beat_legal
                     && (bus.encode_match_length_i != '0);
        out_free   = !out_valid_q || bus.out_ready_i;
        drain      = (cnt_q >= OW_CNT) && out_free;
        pad        = (state_q == ST_FLUSH) && (cnt_q < OW_CNT) && (cnt_q != '0) && out_free;

        acc_d = acc_q;
        cnt_d = cnt_q;
        // ready_q implies cnt_q < OUT_WIDTH, so drain and append never coincide.
        if (drain) begin
            acc_d = acc_q << OUT_WIDTH;
            cnt_d = cnt_q - OW_CNT;
        end else if (pad) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (append) begin
            acc_d = insert_bits(acc_q, bus.encode_match_data_i,
                                bus.encode_match_length_i, cnt_q);
            cnt_d = cnt_q + CNT_W'(bus.encode_match_length_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            ready_q      <= 1'b0;
            flush_done_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;

            if (drain || pad) begin
                out_data_q  <= acc_q[ACC_W-1 -: OUT_WIDTH];
                out_valid_q <= 1'b1;
            end else if (bus.out_ready_i) begin
                out_valid_q <= 1'b0;
            end

            if (accept && bus.encode_match_i && !beat_legal) begin
                len_err_q <= 1'b1;
            end

            flush_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (flush_i) state_q <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if ((cnt_q == '0) || pad) begin
                        state_q      <= ST_DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase

            // Ready is registered from the state and fill level of the next cycle.
            ready_q <= (((state_q == ST_RUN) && !flush_i) || (state_q == ST_DONE))
                       && (cnt_d < OW_CNT);
        end
    end

`ifdef CODEWORD_PACKER_BITCNT_EN
    logic [31:0] bit_count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bit_count_q <= '0;
        end else if (append) begin
            bit_count_q <= bit_count_q + 32'(bus.encode_match_length_i);
        end
    end

    assign bit_count_o = bit_count_q;
`endif

    assign bus.encode_ready_o = ready_q;
    assign bus.out_data_o     = out_data_q;
    assign bus.out_valid_o    = out_valid_q;
    assign flush_done_o       = flush_done_q;
    assign len_err_o          = len_err_q;

endmodule

// File: tb/tb_codeword_packer.sv
// Self-checking bench for codeword_packer: vector table, directed corner
// sequences and randomized beats against a bit-queue reference model.
module tb_codeword_packer;
    import codeword_packer_pkg::*;

    localparam int DL = 21;
    localparam int OW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush_done, len_err;
`ifdef CODEWORD_PACKER_BITCNT_EN
    logic [31:0] bit_count;
`endif

    codeword_packer_if #(.ENCODE_DATALENGTH(DL), .OUT_WIDTH(OW)) bus();

    codeword_packer #(.ENCODE_DATALENGTH(DL), .OUT_WIDTH(OW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .bus          (bus),
        .flush_i      (flush),
        .flush_done_o (flush_done),
        .len_err_o    (len_err)
`ifdef CODEWORD_PACKER_BITCNT_EN
        ,
        .bit_count_o  (bit_count)
`endif
    );

    always #5 clk = ~clk;

    // out_ready: 0 = hold low, 1 = hold high, 2 = random per cycle
    int   ready_mode = 1;
    logic rnd_ready  = 1'b1;
    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end
    assign bus.out_ready_i = (ready_mode == 2) ? rnd_ready : (ready_mode == 1);

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cap_q[$];
    logic [31:0] exp_q[$];
    bit          model_bits[$];
    bit          model_err = 1'b0;
    logic [31:0] model_bitcnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    function automatic void clear_model();
        exp_q.delete();
        model_bits.delete();
        cap_q.delete();
        model_err    = 1'b0;
        model_bitcnt = '0;
    endfunction

    function automatic void model_beat(input logic [20:0] d, input int len);
        logic [31:0] w;
        for (int i = len - 1; i >= 0; i--) model_bits.push_back(d[i]);
        model_bitcnt += 32'(len);
        while (model_bits.size() >= 32) begin
            for (int i = 0; i < 32; i++) w[31-i] = model_bits.pop_front();
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_flush();
        logic [31:0] w;
        if (model_bits.size() > 0) begin
            w = '0;
            for (int i = 0; model_bits.size() > 0; i++) w[31-i] = model_bits.pop_front();
            exp_q.push_back(w);
        end
    endfunction

    // Monitor: observes handshakes away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("len_err", len_err, model_err);
`ifdef CODEWORD_PACKER_BITCNT_EN
            chk("bit_count", bit_count, model_bitcnt);
`endif
            if (bus.out_valid_o && bus.out_ready_i) begin
                cap_q.push_back(bus.out_data_o);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%08h, expected no word", bus.out_data_o);
                end else begin
                    chk("word", bus.out_data_o, exp_q.pop_front());
                end
            end
            if (flush_done)
                chk("flush_drained", exp_q.size(), (bus.out_valid_o && !bus.out_ready_i) ? 1 : 0);
            if (bus.encode_valid_i && bus.encode_ready_o && bus.encode_match_i) begin
                if (bus.encode_match_length_i > 6'(DL)) model_err = 1'b1;
                else if (bus.encode_match_length_i != 0)
                    model_beat(bus.encode_match_data_i, int'(bus.encode_match_length_i));
            end
            if (flush) model_flush();
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.encode_valid_i = 1'b0;
        bus.encode_match_i = 1'b0;
        bus.encode_match_length_i = '0;
        bus.encode_match_data_i = '0;
        ready_mode = 1;
        #1 clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input bit m, input logic [5:0] l, input logic [20:0] d);
        bit ok = 1'b0;
        bus.encode_valid_i = 1'b1;
        bus.encode_match_i = m;
        bus.encode_match_length_i = l;
        bus.encode_match_data_i = d;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (bus.encode_ready_o) ok = 1'b1;
        end
        @(posedge clk);
        #1 bus.encode_valid_i = 1'b0;
        if (!ok) fail_now("beat_accept");
    endtask

    task automatic do_flush();
        bit seen = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (flush_done) seen = 1'b1;
        end
        if (!seen) fail_now("flush_done");
        else begin
            @(negedge clk);
            chk("flush_done_one_cycle", flush_done, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) fail_now(name);
    endtask

    typedef struct {
        int          n_beats;
        logic [5:0]  len;
        logic [20:0] data;
        bit          bad_first;
        bit          interleave;
        int          n_words;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{11, 6'd3,  21'h5,      1'b0, 1'b0, 2, 32'hB6DB6DB6, 32'h80000000, 1'b0};
        vecs[1] = '{2,  6'd21, 21'h1FFFFF, 1'b0, 1'b0, 2, 32'hFFFFFFFF, 32'hFFC00000, 1'b0};
        vecs[2] = '{11, 6'd3,  21'h5,      1'b0, 1'b1, 2, 32'hB6DB6DB6, 32'h80000000, 1'b0};
        vecs[3] = '{1,  6'd3,  21'h5,      1'b1, 1'b0, 1, 32'hA0000000, 32'h0,        1'b1};
        vecs[4] = '{0,  6'd3,  21'h5,      1'b0, 1'b0, 0, 32'h0,        32'h0,        1'b0};
        vecs[5] = '{32, 6'd1,  21'h1,      1'b0, 1'b0, 1, 32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[6] = '{5,  6'd0,  21'h1FFFF,  1'b0, 1'b0, 0, 32'h0,        32'h0,        1'b0};
        vecs[7] = '{8,  6'd4,  21'h1FFFA,  1'b0, 1'b0, 1, 32'hAAAAAAAA, 32'h0,        1'b0};
        vecs[8] = '{0,  6'd3,  21'h5,      1'b1, 1'b0, 0, 32'h0,        32'h0,        1'b1};

        // Outputs while reset is held
        #2;
        chk("rst_out_valid", bus.out_valid_o, 1'b0);
        chk("rst_out_data", bus.out_data_o, 32'h0);
        chk("rst_encode_ready", bus.encode_ready_o, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_len_err", len_err, 1'b0);

        for (int v = 0; v < 9; v++) begin
            do_reset();
            if (vecs[v].bad_first) send_beat(1'b1, 6'd22, 21'($urandom()));
            for (int b = 0; b < vecs[v].n_beats; b++) begin
                if (vecs[v].interleave)
                    send_beat(1'b0, 6'($urandom_range(0, 63)), 21'($urandom()));
                send_beat(1'b1, vecs[v].len, vecs[v].data);
            end
            do_flush();
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_nwords", v), cap_q.size(), vecs[v].n_words);
            if (vecs[v].n_words > 0)
                chk($sformatf("vec%0d_w0", v), (cap_q.size() > 0) ? cap_q[0] : 'x, vecs[v].w0);
            if (vecs[v].n_words > 1)
                chk($sformatf("vec%0d_w1", v), (cap_q.size() > 1) ? cap_q[1] : 'x, vecs[v].w1);
            chk($sformatf("vec%0d_len_err", v), len_err, vecs[v].err);
            $display("vector %0d: %0d beats len=%0d -> %0d words", v, vecs[v].n_beats,
                     vecs[v].len, cap_q.size());
        end

        // Backpressure: 40 len=3 beats with the output stalled
        do_reset();
        ready_mode = 0;
        for (int b = 0; b < 22; b++) send_beat(1'b1, 6'd3, 21'h5);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("bp_encode_ready_low", bus.encode_ready_o, 1'b0);
            chk("bp_out_valid_held", bus.out_valid_o, 1'b1);
            chk("bp_out_data_stable", bus.out_data_o, 32'hB6DB6DB6);
        end
        @(posedge clk);
        #1 ready_mode = 1;
        for (int b = 0; b < 18; b++) send_beat(1'b1, 6'd3, 21'h5);
        do_flush();
        wait_drained("bp_drain");
        chk("bp_nwords", cap_q.size(), 4);
        chk("bp_first_word", (cap_q.size() > 0) ? cap_q[0] : 'x, 32'hB6DB6DB6);
        $display("backpressure: %0d words delivered", cap_q.size());

        // Reset while flushing with 10 bits pending and the output stalled
        do_reset();
        ready_mode = 0;
        for (int b = 0; b < 14; b++) send_beat(1'b1, 6'd3, 21'h5);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid_o, 1'b0);
        chk("midrst_out_data", bus.out_data_o, 32'h0);
        chk("midrst_encode_ready", bus.encode_ready_o, 1'b0);
        chk("midrst_flush_done", flush_done, 1'b0);
        clear_model();
        ready_mode = 1;
        @(negedge clk) rst_n = 1'b1;
        begin
            int pulses = 0;
            repeat (10) begin
                @(negedge clk);
                if (flush_done) pulses++;
            end
            chk("midrst_no_done", pulses, 0);
        end
        @(posedge clk);
        #1;
        for (int b = 0; b < 11; b++) send_beat(1'b1, 6'd3, 21'h5);
        do_flush();
        wait_drained("midrst_drain");
        chk("midrst_nwords", cap_q.size(), 2);
        chk("midrst_w0", (cap_q.size() > 0) ? cap_q[0] : 'x, 32'hB6DB6DB6);
        chk("midrst_w1", (cap_q.size() > 1) ? cap_q[1] : 'x, 32'h80000000);
        $display("reset during flush: %0d words after restart", cap_q.size());

        // Randomized beats, flushes and output backpressure against the model
        do_reset();
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 4) begin
                do_flush();
                $display("random %0d: flush", i);
            end else begin
                logic [5:0] l;
                bit m = ($urandom_range(0, 4) != 0);
                l = ($urandom_range(0, 99) < 3) ? 6'd22 : 6'($urandom_range(0, DL));
                send_beat(m, l, 21'($urandom()));
                $display("random %0d: beat match=%0d len=%0d", i, m, l);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        do_flush();
        ready_mode = 1;
        wait_drained("random_drain");
        chk("random_all_words", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/codeword_packer.md
Name: codeword_packer

Overview:
- Sits directly downstream of the low-entropy codebook selection stage.
- Consumes its per-cycle result: a match flag, a codeword length and codeword bits (right-aligned).
- Concatenates matched codewords MSB-first into fixed OUT_WIDTH-bit words for the output bitstream writer, with valid/ready on both sides.
- Supports an explicit flush that zero-pads and emits the final partial word.

Parameters:
- ENCODE_DATALENGTH, 21, width of codeword data input; maximum legal codeword length.
- OUT_WIDTH, 32, packed output word width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- encode_valid_i  in  1  codeword beat valid
- encode_ready_o  out  1  codeword beat accepted when valid&&ready
- encode_match_i  in  1  beat carries a codeword; 0 = beat consumed, no bits appended
- encode_match_length_i  in  6  codeword length in bits (0..ENCODE_DATALENGTH legal)
- encode_match_data_i  in  ENCODE_DATALENGTH  codeword, right-aligned; bits above length ignored
- flush_i  in  1  request: drain and pad the remaining bits
- out_data_o  out  OUT_WIDTH  packed word; first codeword bit at MSB
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  downstream accepts word
- flush_done_o  out  1  one-cycle pulse when flush complete
- len_err_o  out  1  sticky: a beat with match=1 and length>ENCODE_DATALENGTH was received

Behaviour:
- Reset (rst_i=0, async): all outputs 0; acc=0; cnt=0; state=RUN. This applies mid-flush as well, and any partial word is discarded.
- Storage:
  - acc: ACC_W = OUT_WIDTH+ENCODE_DATALENGTH bits, left-aligned.
  - cnt: number of valid bits in acc, 0..ACC_W-1.
- encode_ready_o = (state==RUN) && (cnt<OUT_WIDTH).
- Accept with match=1, 1≤len≤ENCODE_DATALENGTH:
  - data[len-1:0] is written to acc[ACC_W-1-cnt -: len].
  - cnt += len.
- Accept with match=0 or len=0: no change.
- Accept with match=1, len>ENCODE_DATALENGTH: beat dropped; len_err_o set; it clears only on reset.
- Drain:
  - Condition: cnt≥OUT_WIDTH and (!out_valid_o || out_ready_i).
  - Action: out_data_o ← acc[ACC_W-1 -: OUT_WIDTH]; out_valid_o←1; acc <<= OUT_WIDTH; cnt -= OUT_WIDTH.
  - Drain and accept are mutually exclusive by construction.
- Output handshake:
  - out_valid_o holds, with out_data_o stable, until out_ready_i.
  - If acked with no new drain in that cycle, out_valid_o←0 next edge.
- Latency and throughput:
  - Word appears at the edge after cnt reaches ≥OUT_WIDTH, provided the output register is free.
  - Sustained one beat/cycle, except one stall cycle per emitted word.
- FSM RUN → FLUSH → DONE → RUN:
  - RUN: on flush_i=1 go to FLUSH. A beat accepted in the same cycle is appended before the flush.
  - FLUSH: encode_ready_o=0; full words drain as normal. Once cnt<OUT_WIDTH, cnt>0 and the output register is free, emit acc top bits with zero padding and set cnt←0. Then go to DONE. If cnt=0, go to DONE directly.
  - DONE: flush_done_o=1 for this cycle only; return to RUN.
  - flush_i while in FLUSH/DONE is ignored.
- Boundary: the flush pulse is asserted only after the padded word has been loaded into out_data_o, not after it is acked.

Optional Feature:
- Macro: CODEWORD_PACKER_BITCNT_EN.
- When defined:
  - Adds output bit_count_o [31:0]: total codeword bits accepted since reset, excluding padding and dropped beats.
  - Wraps modulo 2^32 and is reset to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package codeword_packer_pkg holds:
  - the state enum (RUN, FLUSH, DONE);
  - the ACC_W derivation function;
  - the legal-length check function, shared with the codebook stage's length width (6 bits).
- No sub-module required; the left-aligned insert (mask+shift) may be a function in the package.

Test Plan:
- 11 beats match=1, len=3, data=3'b101 → one word 0xB6DB6DB6, cnt=1. Then flush_i → word 0x80000000, then flush_done_o pulse.
- 2 beats len=21, data=0x1FFFFF → word 0xFFFFFFFF. Then flush → 0xFFC00000.
- Beats with match=0 (any length/data) interleaved with len=3 data=101 → output identical to the first scenario; no extra bits.
- Beat match=1 len=22 → len_err_o=1 sticky, no bits appended. A following len=3 beat packs normally.
- out_ready_i held 0 while driving 40 len=3 beats:
  - encode_ready_o drops once cnt≥32;
  - out_data_o stays stable;
  - on release, all words arrive in order with no loss.
- Assert rst_i=0 during FLUSH with 10 bits pending → all outputs 0 immediately. After release, new beats pack from an empty accumulator; no flush_done_o pulse.
